program_load_ctrl: RTL and testbench
====================================

// Module: program_load_ctrl
// PURPOSE
//  Sequences CPU program loading from the UART receiver into 32x8 instruction memory.
//  - On Load: holds CPU, takes a length byte, N payload bytes and a checksum byte from the RX stream.
//  - Writes the payload bytes to addresses 0..N-1.
//  - On checksum match: pulses CPU reset and releases hold.
//  Sits between the UART RX block and the CPU core / instruction memory.
// PARAMETERS
//  ADDR_W          5     instruction memory address width (depth 2**ADDR_W = 32)
//  DATA_W          8     byte width
//  TIMEOUT_CYCLES  4096  max Clk cycles between accepted bytes while loading
// PORTS
//  Clk           in   1       system clock, all logic on rising edge
//  Reset         in   1       synchronous, active-high reset
//  Load          in   1       start/restart program load; level, sampled each cycle
//  rx_data       in   8       received byte from UART RX
//  rx_valid      in   1       one-cycle strobe, rx_data/rx_fe valid
//  rx_fe         in   1       frame error flag for the current byte
//  mem_we        out  1       instruction memory write enable
//  mem_addr      out  5       instruction memory write address
//  mem_wdata     out  8       instruction memory write data
//  cpu_hold      out  1       1 = CPU stalled (PC frozen, no fetch)
//  cpu_rst       out  1       one-cycle CPU reset pulse before run
//  busy          out  1       1 while in LEN/DATA/CSUM
//  done          out  1       1 while in RUN
//  err_code      out  2       0 none, 1 frame error, 2 bad length/checksum, 3 timeout
//  bytes_loaded  out  6       payload bytes written in current/last load (0..32)
// BEHAVIOUR
//  - Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_rst=0, busy=0, done=0,
//    err_code=0, bytes_loaded=0, checksum=0, timer=0.
//  - States: IDLE, LEN, DATA, CSUM, START, RUN, ERROR.
//  - IDLE --Load--> LEN.
//  - LEN: byte L accepted.
//    - L==0 or L>32 -> ERROR, err_code=2.
//    - else cnt=L, addr=0, checksum=0 -> DATA.
//  - DATA: each accepted byte is registered.
//    - Cycle after rx_valid: mem_we=1 for exactly one cycle; mem_addr=addr, mem_wdata=byte.
//    - Then addr+1, bytes_loaded+1, checksum+=byte.
//    - After the L-th byte -> CSUM.
//  - Checksum arithmetic: 8-bit sum modulo 256; carry discarded (wrap-around).
//  - CSUM: byte==checksum -> START, else ERROR with err_code=2.
//  - START: one cycle, cpu_rst=1 and cpu_hold=1 -> RUN.
//  - RUN: cpu_hold=0, done=1; remains until Load or Reset.
//  - ERROR: cpu_hold=1, err_code held; exits only via Load or Reset.
//  - rx_fe=1 with rx_valid in LEN/DATA/CSUM -> ERROR, err_code=1; byte not written, not summed.
//  - Timer: cleared on Load and on every accepted rx_valid; counts in LEN/DATA/CSUM.
//    Reaching TIMEOUT_CYCLES-1 -> ERROR, err_code=3.
//  - Load asserted in any state (including mid-load or RUN):
//    - Next state LEN; cpu_hold=1; err_code, bytes_loaded, addr, checksum cleared.
//    - Load has priority over a same-cycle rx_valid; that byte is discarded.
//  - Load held high for multiple cycles: stay in LEN with counters cleared; first byte counts only after Load=0.
//  - rx_valid in IDLE/START/RUN/ERROR: ignored.
//  - Reset has priority over everything, in any state, including mid-write. A pending mem_we is cancelled.
//  - Output flags (busy, done, cpu_hold, cpu_rst) are registered and state-decoded; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package cpu_pkg: state encoding enum (7 states, 3 bits), ERR_* codes (2 bits), MEM_DEPTH=32.
//  - Sub-module load_timeout_timer: clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES).
//  - FSM, address/count registers and checksum accumulator stay inline.
// TESTING
//  1. Load pulse, then bytes 03,11,22,33,66:
//     mem writes [0]=11, [1]=22, [2]=33; cpu_rst pulses 1 cycle; done=1; cpu_hold=0; bytes_loaded=3.
//  2. Bytes 02,FF,02, then checksum 01 (FF+02 wraps to 01): RUN reached; bad checksum 00 instead -> err_code=2, cpu_hold=1.
//  3. Length byte 00, and separately 21 (33): ERROR, err_code=2, no mem_we ever asserted.
//  4. Frame error on second payload byte (rx_fe=1): err_code=1, bytes_loaded=1, no write to address 1.
//  5. Stop after 1 of 4 bytes with TIMEOUT_CYCLES=64: err_code=3 exactly 63 cycles after the last rx_valid.
//  6. Load during DATA, coincident with rx_valid: byte dropped, state LEN, counters 0.
//     Then a fresh 01,AA,AA sequence loads; Reset mid-DATA returns all outputs to reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: FSM state encoding, error codes
// and instruction memory depth.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_START,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_BAD     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int MEM_DEPTH = 32;

endpackage

// File: rtl/load_timeout_timer.sv
// Inter-byte timeout counter for the program loader.
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_clr     clear counter to 0 (wins over enable)
//   i_en      count this cycle
//   o_expire  counter reaches TIMEOUT_CYCLES-1 on this clock edge
module load_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] PREV = W'(TIMEOUT_CYCLES - 2);

  logic [W-1:0] r_cnt;

  // Flag the edge on which the count lands on the last value, so the FSM
  // enters ERROR on that same edge.
  assign o_expire = i_en && !i_clr && (r_cnt == PREV);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr)
      r_cnt <= '0;
    else if (i_en && r_cnt != LAST)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/program_load_ctrl.sv
// Program loader: takes length, payload and checksum bytes from the UART RX
// stream, writes the payload to instruction memory from address 0, and on a
// good checksum pulses CPU reset and releases the CPU hold.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Load                  start/restart a load (level)
//   rx_data/valid/fe      received byte, strobe, frame error
//   mem_we/addr/wdata     instruction memory write port
//   cpu_hold, cpu_rst     CPU stall and one-cycle reset pulse
//   busy, done            loading / running status
//   err_code              0 none, 1 frame, 2 length/checksum, 3 timeout
//   bytes_loaded          payload bytes written in current/last load
module program_load_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_fe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   bytes_loaded
);

  state_t            r_state, w_next;
  logic [1:0]        r_err, w_next_err;
  logic [ADDR_W:0]   r_cnt;     // payload length L
  logic [ADDR_W:0]   r_bytes;   // doubles as the next write address
  logic [DATA_W-1:0] r_csum;
  logic              w_wr, w_in_load, w_expire;

  assign w_in_load = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);

  load_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (Clk),
    .i_reset  (Reset),
    .i_clr    (Load || rx_valid || !w_in_load),
    .i_en     (w_in_load),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next     = r_state;
    w_next_err = r_err;
    w_wr       = 1'b0;
    if (Load) begin
      w_next     = ST_LEN;
      w_next_err = ERR_NONE;
    end else if (w_in_load && rx_valid && rx_fe) begin
      w_next     = ST_ERROR;
      w_next_err = ERR_FRAME;
    end else if (w_in_load && rx_valid) begin
      unique case (r_state)
        ST_LEN: begin
          if (rx_data == '0 || rx_data > DATA_W'(MEM_DEPTH)) begin
            w_next     = ST_ERROR;
            w_next_err = ERR_BAD;
          end else begin
            w_next = ST_DATA;
          end
        end
        ST_DATA: begin
          w_wr = 1'b1;
          if (r_bytes + 1'b1 == r_cnt) w_next = ST_CSUM;
        end
        default: begin  // ST_CSUM
          if (rx_data == r_csum) begin
            w_next = ST_START;
          end else begin
            w_next     = ST_ERROR;
            w_next_err = ERR_BAD;
          end
        end
      endcase
    end else if (w_expire) begin
      w_next     = ST_ERROR;
      w_next_err = ERR_TIMEOUT;
    end else if (r_state == ST_START) begin
      w_next = ST_RUN;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Status flags decode the next state so they line up with r_state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_err     <= ERR_NONE;
      r_cnt     <= '0;
      r_bytes   <= '0;
      r_csum    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      cpu_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_err    <= w_next_err;
      mem_we   <= w_wr;
      cpu_hold <= (w_next != ST_RUN);
      cpu_rst  <= (w_next == ST_START);
      done     <= (w_next == ST_RUN);
      busy     <= (w_next == ST_LEN) || (w_next == ST_DATA) || (w_next == ST_CSUM);
      if (Load) begin
        r_cnt   <= '0;
        r_bytes <= '0;
        r_csum  <= '0;
      end else if (r_state == ST_LEN && w_next == ST_DATA) begin
        r_cnt   <= rx_data[ADDR_W:0];
        r_bytes <= '0;
        r_csum  <= '0;
      end else if (w_wr) begin
        mem_addr  <= r_bytes[ADDR_W-1:0];
        mem_wdata <= rx_data;
        r_bytes   <= r_bytes + 1'b1;
        r_csum    <= r_csum + rx_data;  // modulo-256 wrap
      end
    end
  end

  assign err_code     = r_err;
  assign bytes_loaded = r_bytes;

endmodule

// File: tb/tb_program_load_ctrl.sv
module tb_program_load_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Load, rx_valid, rx_fe;
  logic [7:0] rx_data;
  logic       mem_we, cpu_hold, cpu_rst, busy, done;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [1:0] err_code;
  logic [5:0] bytes_loaded;

  program_load_ctrl #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(64)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_fe(rx_fe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err_code(err_code), .bytes_loaded(bytes_loaded)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_miss = 0, rst_cycles = 0;

  typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we cycle must match the oldest expected write.
  always @(negedge Clk) begin
    if (cpu_rst) rst_cycles++;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {19'd0, mem_addr, mem_wdata}, 32'hDEAD_BEEF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr", {19'd0, mem_addr, mem_wdata}, {19'd0, w.a, w.d});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input logic fe);
    rx_data = d; rx_fe = fe; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0; rx_fe = 1'b0;
  endtask

  task automatic byte_gap(input logic [7:0] d);
    send(d, 1'b0); tick(2);
  endtask

  task automatic pay(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
    byte_gap(d);
  endtask

  task automatic load_pulse();
    Load = 1'b1; tick(1); Load = 1'b0; tick(1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_rst"}, cpu_rst, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_code, 0);
    chk({tag, "_bytes"}, bytes_loaded, 0);
  endtask

  initial begin
    int k;
    Reset = 1'b1; Load = 1'b0; rx_valid = 1'b0; rx_fe = 1'b0; rx_data = 8'h00;
    tick(3);
    Reset = 1'b0;
    tick(1);
    chk_reset_outs("reset");
    send(8'h05, 1'b0);              // ignored in IDLE
    tick(2);
    chk("idle_busy", busy, 0);

    // 1: basic load and run
    load_pulse();
    chk("t1_busy", busy, 1);
    chk("t1_hold", cpu_hold, 1);
    byte_gap(8'h03);
    pay(5'd0, 8'h11); pay(5'd1, 8'h22); pay(5'd2, 8'h33);
    rst_cycles = 0;
    byte_gap(8'h66);
    tick(1);
    chk("t1_rst_cycles", rst_cycles, 1);
    chk("t1_done", done, 1);
    chk("t1_hold_run", cpu_hold, 0);
    chk("t1_bytes", bytes_loaded, 3);
    chk("t1_err", err_code, 0);
    chk("t1_q", exp_q.size(), 0);

    // 2: checksum wraps mod 256, then bad checksum
    load_pulse();
    chk("t2_hold_reload", cpu_hold, 1);
    byte_gap(8'h02); pay(5'd0, 8'hFF); pay(5'd1, 8'h02);
    byte_gap(8'h01); tick(1);
    chk("t2_done", done, 1);
    load_pulse();
    byte_gap(8'h02); pay(5'd0, 8'hFF); pay(5'd1, 8'h02);
    byte_gap(8'h00);
    chk("t2_bad_err", err_code, 2);
    chk("t2_bad_hold", cpu_hold, 1);
    chk("t2_bad_done", done, 0);

    // 3: illegal lengths
    load_pulse();
    chk("t3_err_clr", err_code, 0);
    byte_gap(8'h00);
    chk("t3_len0_err", err_code, 2);
    load_pulse();
    byte_gap(8'h21);
    chk("t3_len33_err", err_code, 2);
    chk("t3_len33_bytes", bytes_loaded, 0);

    // 4: frame error on second payload byte
    load_pulse();
    byte_gap(8'h03); pay(5'd0, 8'hAB);
    send(8'hCD, 1'b1); tick(2);
    chk("t4_err", err_code, 1);
    chk("t4_bytes", bytes_loaded, 1);
    chk("t4_busy", busy, 0);

    // 5: timeout 63 cycles after the last accepted byte
    load_pulse();
    byte_gap(8'h04);
    exp_q.push_back('{a: 5'd0, d: 8'h5A});
    send(8'h5A, 1'b0);
    k = 0;
    while (err_code !== 2'd3 && k < 200) begin tick(1); k++; end
    chk("t5_timeout_cycles", k, 63);
    chk("t5_bytes", bytes_loaded, 1);

    // 6: Load coincident with rx_valid mid-DATA
    load_pulse();
    byte_gap(8'h03); pay(5'd0, 8'h10);
    Load = 1'b1; rx_data = 8'h20; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    byte_gap(8'h02);                // Load still high: dropped
    Load = 1'b0; tick(1);
    chk("t6_busy", busy, 1);
    chk("t6_bytes", bytes_loaded, 0);
    chk("t6_err", err_code, 0);
    byte_gap(8'h01); pay(5'd0, 8'hAA); byte_gap(8'hAA); tick(1);
    chk("t6_done", done, 1);
    chk("t6_bytes_run", bytes_loaded, 1);
    load_pulse();
    byte_gap(8'h02); pay(5'd0, 8'h55);
    rx_data = 8'h66; rx_valid = 1'b1; Reset = 1'b1;   // write cancelled by reset
    tick(1);
    rx_valid = 1'b0; Reset = 1'b0;
    tick(2);
    chk_reset_outs("t6_reset");
    chk("t6_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
